// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: word width, store-buffer entry width, load-port states.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Entry width is index + data so the buffer can forward whole words by RAM index.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef SB_ENTRY_W
`define SB_ENTRY_W(idx_w, dat_w) ((idx_w) + (dat_w))
`endif

package mem_responder_pkg;

    localparam int WORD_WIDTH = `WORD_WIDTH;

    // Load data port: either free for a new load, or owed to a load that lost to a full-buffer drain.
    typedef enum logic {
        LD_IDLE  = 1'b0,
        LD_RETRY = 1'b1
    } ld_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side bus of the memory responder: fetch, load and store ends.
// Fetch and load results arrive one cycle after the request (loads two when the buffer is full).
// Stores are flow-controlled by s_ready; fetch and load have no backpressure signal.
interface mem_responder_if #(
    parameter int W = mem_responder_pkg::WORD_WIDTH
);
    logic [W-1:0] pc;
    logic [W-1:0] inst;
    logic         load_en;
    logic [W-1:0] l_addr;
    logic [W-1:0] l_data;
    logic         l_valid;
    logic         store_en;
    logic [W-1:0] s_addr;
    logic [W-1:0] s_data;
    logic         s_ready;

    modport master (
        output pc, load_en, l_addr, store_en, s_addr, s_data,
        input  inst, l_data, l_valid, s_ready
    );

    modport slave (
        input  pc, load_en, l_addr, store_en, s_addr, s_data,
        output inst, l_data, l_valid, s_ready
    );
endinterface

// File: rtl/mem_responder_store_buffer.sv
// In-order circular store buffer with a youngest-first forwarding lookup by RAM word index.
// Push/pop take effect at the next edge; lookup and head outputs are combinational on registered state.
// Pushes while full and pops while empty are ignored; the caller gates push with !full_o.
module mem_responder_store_buffer #(
    parameter int W        = 32,
    parameter int IDX_W    = 10,
    parameter int SB_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [IDX_W-1:0] head_idx_o,
    output logic [W-1:0]     head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    input  logic [IDX_W-1:0] lkup_idx_i,
    output logic             lkup_hit_o,
    output logic [W-1:0]     lkup_dat_o
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int ENT_W = `SB_ENTRY_W(IDX_W, W);

    logic [ENT_W-1:0] ent_q [SB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   cnt_q,  cnt_d;
    logic             do_push, do_pop;

    assign full_o     = (cnt_q == (PTR_W+1)'(SB_DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_idx_o = ent_q[head_q][ENT_W-1:W];
    assign head_dat_o = ent_q[head_q][W-1:0];

    // Pointer and occupancy next state; pointers wrap naturally at SB_DEPTH.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    // Pointer and occupancy registers; reset discards every pending store.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage is written only at the tail and needs no reset; occupancy says what is live.
    always_ff @(posedge clk) begin
        if (do_push) ent_q[tail_q] <= {push_idx_i, push_dat_i};
    end

    // Walk live entries oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        logic [PTR_W-1:0] pos;
        pos        = '0;
        lkup_hit_o = 1'b0;
        lkup_dat_o = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < cnt_q) && (ent_q[pos][ENT_W-1:W] == lkup_idx_i)) begin
                lkup_hit_o = 1'b1;
                lkup_dat_o = ent_q[pos][W-1:0];
            end
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: word RAM with registered fetch/load read ports and a posted, forwarding store buffer.
// Fetch latency 1; load latency 1, or 2 when the load meets a full buffer (drain wins, load retried).
// Stores back-pressure through s_ready (buffer not full); fetch never stalls, a retrying load blocks new loads.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int W          = WORD_WIDTH,
    parameter int DEPTH_LOG2 = 10,
    parameter int SB_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_responder_if.slave bus
);
    logic [W-1:0]          ram_q [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0] pc_idx, l_idx, s_idx, ld_idx;
    ld_state_e             ld_state_q, ld_state_d;
    logic [DEPTH_LOG2-1:0] retry_idx_q, retry_idx_d;

    logic                  sb_full, sb_empty, sb_hit;
    logic [W-1:0]          sb_fwd_dat, sb_head_dat;
    logic [DEPTH_LOG2-1:0] sb_head_idx;

    logic                  load_req, ld_accept, drain, push;
    logic [W-1:0]          inst_q, l_data_q;
    logic                  l_valid_q;
    logic                  unused_addr_bits;

    // Word index ignores the byte offset and wraps modulo the RAM size.
    assign pc_idx = bus.pc[DEPTH_LOG2+1:2];
    assign l_idx  = bus.l_addr[DEPTH_LOG2+1:2];
    assign s_idx  = bus.s_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{bus.pc[W-1:DEPTH_LOG2+2], bus.pc[1:0],
                                bus.l_addr[W-1:DEPTH_LOG2+2], bus.l_addr[1:0],
                                bus.s_addr[W-1:DEPTH_LOG2+2], bus.s_addr[1:0]};

    // s_ready comes from the registered count, so a drain in the same cycle cannot make room.
    assign push = bus.store_en && !sb_full;

    mem_responder_store_buffer #(
        .W        (W),
        .IDX_W    (DEPTH_LOG2),
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_idx_i (s_idx),
        .push_dat_i (bus.s_data),
        .pop_i      (drain),
        .head_idx_o (sb_head_idx),
        .head_dat_o (sb_head_dat),
        .full_o     (sb_full),
        .empty_o    (sb_empty),
        .lkup_idx_i (ld_idx),
        .lkup_hit_o (sb_hit),
        .lkup_dat_o (sb_fwd_dat)
    );

    // Data-port arbitration and retry FSM: a load owns the port unless the buffer is full.
    always_comb begin
        ld_state_d  = ld_state_q;
        retry_idx_d = retry_idx_q;
        load_req    = (ld_state_q == LD_RETRY) || bus.load_en;
        ld_accept   = load_req && !sb_full;
        drain       = !sb_empty && (!load_req || sb_full);
        ld_idx      = (ld_state_q == LD_RETRY) ? retry_idx_q : l_idx;
        case (ld_state_q)
            LD_IDLE: begin
                if (bus.load_en && sb_full) begin
                    ld_state_d  = LD_RETRY;
                    retry_idx_d = l_idx;
                end
            end
            LD_RETRY: begin
                if (!sb_full) ld_state_d = LD_IDLE;
            end
            default: ld_state_d = LD_IDLE;
        endcase
    end

    // RAM write port drains the buffer head; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (drain && !rst) ram_q[sb_head_idx] <= sb_head_dat;
    end

    // Registered fetch and load read ports plus load-port state.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q      <= '0;
            l_data_q    <= '0;
            l_valid_q   <= 1'b0;
            ld_state_q  <= LD_IDLE;
            retry_idx_q <= '0;
        end else begin
            inst_q      <= ram_q[pc_idx];
            l_valid_q   <= ld_accept;
            ld_state_q  <= ld_state_d;
            retry_idx_q <= retry_idx_d;
            if (ld_accept) l_data_q <= sb_hit ? sb_fwd_dat : ram_q[ld_idx];
        end
    end

    assign bus.inst    = inst_q;
    assign bus.l_data  = l_data_q;
    assign bus.l_valid = l_valid_q;
    assign bus.s_ready = !sb_full;
endmodule
